icache: RTL and testbench



---
 rtl/icache_if.sv | 35 +++
 rtl/icache.sv | 215 +++++++++++++++++++++
 tb/tb_icache.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/icache_if.sv
// rtl/icache_if.sv - fetch-side and memory-side signal bundle for the instruction cache
//
// Purpose: groups the fetch request/response and the memory-controller word-read
// handshake so the cache and its environment connect through one port.
// Ports (signals):
//   valid_from_if, pc_from_if       fetch request (held until the response is seen)
//   valid_to_if, inst_to_if         one-cycle response pulse and instruction word
//   rollback_from_rob               flush of any pending response
//   mem_valid_to_ctrl, mem_addr_to_ctrl      word-read request and address
//   mem_done_from_ctrl, mem_data_from_ctrl   one-cycle completion pulse and word
// Modports: master = fetch/ROB/memory environment, slave = the cache.

interface icache_if;
  logic        valid_from_if;
  logic [31:0] pc_from_if;
  logic        valid_to_if;
  logic [31:0] inst_to_if;
  logic        rollback_from_rob;
  logic        mem_valid_to_ctrl;
  logic [31:0] mem_addr_to_ctrl;
  logic        mem_done_from_ctrl;
  logic [31:0] mem_data_from_ctrl;

  modport master (
    output valid_from_if, pc_from_if, rollback_from_rob,
    output mem_done_from_ctrl, mem_data_from_ctrl,
    input  valid_to_if, inst_to_if, mem_valid_to_ctrl, mem_addr_to_ctrl
  );

  modport slave (
    input  valid_from_if, pc_from_if, rollback_from_rob,
    input  mem_done_from_ctrl, mem_data_from_ctrl,
    output valid_to_if, inst_to_if, mem_valid_to_ctrl, mem_addr_to_ctrl
  );
endinterface

// File: rtl/icache.sv
// rtl/icache.sv - direct-mapped read-only instruction cache with word-serial line fill
//
// Purpose: answers held-valid fetch requests with one-cycle response pulses. Hits
// respond one cycle after the request is sampled; misses fill the whole line one
// 32-bit word at a time (ascending from word 0) and then respond. A rollback
// cancels any pending response; a started fill always completes and installs.
// Ports:
//   clk         clock
//   rst         synchronous active-high reset
//   rdy         global ready; low freezes every register
//   bus         icache_if.slave (fetch request/response, rollback, memory reads)
//   hit_count   (ICACHE_PERF_EN only) saturating count of IDLE hit responses
//   miss_count  (ICACHE_PERF_EN only) saturating count of IDLE->FILL transitions
// Optional feature macro: ICACHE_PERF_EN

module icache #(
  parameter int INDEX_WIDTH    = 4,
  parameter int WORD_SEL_WIDTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  icache_if.slave     bus
`ifdef ICACHE_PERF_EN
  ,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
`endif
);

  localparam int LINES     = 1 << INDEX_WIDTH;
  localparam int WORDS     = 1 << WORD_SEL_WIDTH;
  localparam int OFF_W     = WORD_SEL_WIDTH + 2;
  localparam int TAG_LSB   = OFF_W + INDEX_WIDTH;
  localparam int TAG_WIDTH = 32 - TAG_LSB;

  typedef enum logic [1:0] {IDLE, FILL, RESP} state_t;

  state_t state, state_n;

  // Line storage; only the valid bits are reset.
  logic [31:0]          data_mem [LINES][WORDS];
  logic [TAG_WIDTH-1:0] tag_mem  [LINES];
  logic [LINES-1:0]     line_valid;

  logic                      valid_q, valid_n;
  logic [31:0]               inst_q, inst_n;
  logic                      mem_valid_q, mem_valid_n;
  logic [31:0]               mem_addr_q, mem_addr_n;
  logic                      drop_q, drop_n;
  logic [WORD_SEL_WIDTH-1:0] cnt_q, cnt_n;
  logic [31:2]               req_pc_q, req_pc_n;

  logic fill_we;
  logic line_done;

  // Incoming request address split.
  logic [WORD_SEL_WIDTH-1:0] pc_word;
  logic [INDEX_WIDTH-1:0]    pc_index;
  logic [TAG_WIDTH-1:0]      pc_tag;
  logic                      hit;
  logic                      unused_pc_lsb;

  assign pc_word       = bus.pc_from_if[OFF_W-1:2];
  assign pc_index      = bus.pc_from_if[TAG_LSB-1:OFF_W];
  assign pc_tag        = bus.pc_from_if[31:TAG_LSB];
  assign hit           = line_valid[pc_index] && (tag_mem[pc_index] == pc_tag);
  assign unused_pc_lsb = ^bus.pc_from_if[1:0];

  // Latched miss address split, used throughout the fill.
  logic [WORD_SEL_WIDTH-1:0] req_word;
  logic [INDEX_WIDTH-1:0]    req_index;
  logic [TAG_WIDTH-1:0]      req_tag;

  assign req_word  = req_pc_q[OFF_W-1:2];
  assign req_index = req_pc_q[TAG_LSB-1:OFF_W];
  assign req_tag   = req_pc_q[31:TAG_LSB];

  assign bus.valid_to_if       = valid_q;
  assign bus.inst_to_if        = inst_q;
  assign bus.mem_valid_to_ctrl = mem_valid_q;
  assign bus.mem_addr_to_ctrl  = mem_addr_q;

  always_comb begin
    state_n     = state;
    valid_n     = valid_q;
    inst_n      = inst_q;
    mem_valid_n = mem_valid_q;
    mem_addr_n  = mem_addr_q;
    drop_n      = drop_q;
    cnt_n       = cnt_q;
    req_pc_n    = req_pc_q;
    fill_we     = 1'b0;
    line_done   = 1'b0;

    case (state)
      IDLE: begin
        if (bus.rollback_from_rob) begin
          // A request arriving together with a flush belongs to the wrong path.
          valid_n = 1'b0;
        end else if (bus.valid_from_if) begin
          if (hit) begin
            valid_n = 1'b1;
            inst_n  = data_mem[pc_index][pc_word];
            state_n = RESP;
          end else begin
            req_pc_n    = bus.pc_from_if[31:2];
            mem_addr_n  = {bus.pc_from_if[31:OFF_W], {OFF_W{1'b0}}};
            mem_valid_n = 1'b1;
            cnt_n       = '0;
            state_n     = FILL;
          end
        end
      end

      FILL: begin
        if (bus.rollback_from_rob) begin
          drop_n = 1'b1;
        end
        if (bus.mem_done_from_ctrl) begin
          fill_we = 1'b1;
          cnt_n   = cnt_q + 1'b1;
          if (!(&cnt_q)) begin
            mem_addr_n = mem_addr_q + 32'd4;
          end else begin
            mem_valid_n = 1'b0;
            line_done   = 1'b1;
            // A flush in the completing cycle also cancels the response.
            if (drop_q || bus.rollback_from_rob) begin
              drop_n  = 1'b0;
              state_n = IDLE;
            end else begin
              valid_n = 1'b1;
              // The requested word may be the one arriving right now.
              inst_n  = (cnt_q == req_word) ? bus.mem_data_from_ctrl
                                            : data_mem[req_index][req_word];
              state_n = RESP;
            end
          end
        end
      end

      RESP: begin
        // The request is still high here while fetch drops it; do not serve it again.
        valid_n = 1'b0;
        state_n = IDLE;
      end

      default: begin
        valid_n = 1'b0;
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      valid_q     <= 1'b0;
      inst_q      <= '0;
      mem_valid_q <= 1'b0;
      mem_addr_q  <= '0;
      drop_q      <= 1'b0;
      cnt_q       <= '0;
      req_pc_q    <= '0;
      line_valid  <= '0;
    end else if (rdy) begin
      state       <= state_n;
      valid_q     <= valid_n;
      inst_q      <= inst_n;
      mem_valid_q <= mem_valid_n;
      mem_addr_q  <= mem_addr_n;
      drop_q      <= drop_n;
      cnt_q       <= cnt_n;
      req_pc_q    <= req_pc_n;
      if (line_done) begin
        line_valid[req_index] <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && rdy) begin
      if (fill_we) begin
        data_mem[req_index][cnt_q] <= bus.mem_data_from_ctrl;
      end
      if (line_done) begin
        tag_mem[req_index] <= req_tag;
      end
    end
  end

`ifdef ICACHE_PERF_EN
  logic hit_evt;
  logic miss_evt;

  assign hit_evt  = (state == IDLE) && bus.valid_from_if && !bus.rollback_from_rob && hit;
  assign miss_evt = (state == IDLE) && bus.valid_from_if && !bus.rollback_from_rob && !hit;

  always_ff @(posedge clk) begin
    if (rst) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else if (rdy) begin
      if (hit_evt && (hit_count != 32'hFFFF_FFFF)) begin
        hit_count <= hit_count + 32'd1;
      end
      if (miss_evt && (miss_count != 32'hFFFF_FFFF)) begin
        miss_count <= miss_count + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_icache.sv
// tb/tb_icache.sv - self-checking bench for icache with a word-serial memory responder

module tb_icache;

  logic clk = 1'b0;
  logic rst;
  logic rdy;

  always #5 clk = ~clk;

  icache_if bus();

`ifdef ICACHE_PERF_EN
  logic [31:0] hit_count;
  logic [31:0] miss_count;
`endif

  icache #(.INDEX_WIDTH(4), .WORD_SEL_WIDTH(2)) dut (
    .clk (clk),
    .rst (rst),
    .rdy (rdy),
    .bus (bus)
`ifdef ICACHE_PERF_EN
    ,
    .hit_count  (hit_count),
    .miss_count (miss_count)
`endif
  );

  typedef struct {
    logic [31:0] pc;
    bit          hit;
    logic [31:0] base;      // first expected read address
    logic [31:0] dbase;     // memory returns dbase + k for read k
    logic [31:0] inst;
    int          rb_after;  // rollback after this many reads (-1: none)
    int          st_after;  // rdy stall after this many reads (-1: none)
    int          lat;       // cycles from request to response pulse
  } vec_t;

  int   tests = 0;
  int   fails = 0;
  int   cur_vec = 0;
  int   exp_hits = 0;
  int   exp_misses = 0;
  vec_t vecs[12];
  vec_t last_vec;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s (vec %0d): got %h expected %h", name, cur_vec, act, exp);
    end
  endtask

  // Issues one fetch and acts as memory: each read is answered one cycle after it
  // is seen, followed by one idle cycle. Fetch drops its request one cycle after
  // the pulse, so the request is still high while the cache is in RESP.
  task automatic run_fetch(input vec_t v);
    int          reads = 0;
    int          pulses = 0;
    int          lat = -1;
    int          stall_left = 0;
    logic [31:0] got = '0;
    logic [31:0] stall_addr = '0;
    bit          drop_pending = 1'b0;

    bus.pc_from_if    = v.pc;
    bus.valid_from_if = 1'b1;
    for (int cyc = 1; cyc <= 25; cyc++) begin
      @(negedge clk);
      bus.rollback_from_rob = 1'b0;
      if (stall_left > 0) begin
        check("stall_addr", bus.mem_addr_to_ctrl, stall_addr);
        check("stall_mem_valid", {31'd0, bus.mem_valid_to_ctrl}, 32'd1);
        stall_left--;
        if (stall_left == 0) rdy = 1'b1;
        continue;
      end
      if (bus.valid_to_if) begin
        pulses++;
        if (pulses == 1) begin
          got = bus.inst_to_if;
          lat = cyc;
        end
        drop_pending = 1'b1;
      end else if (drop_pending) begin
        bus.valid_from_if = 1'b0;
        drop_pending = 1'b0;
      end
      if (bus.mem_done_from_ctrl) begin
        bus.mem_done_from_ctrl = 1'b0;
        if (reads == v.rb_after) begin
          bus.rollback_from_rob = 1'b1;
          bus.valid_from_if     = 1'b0;
        end
        if (reads == v.st_after) begin
          rdy        = 1'b0;
          stall_left = 3;
          stall_addr = v.base + 32'(4 * reads);
        end
      end else if (bus.mem_valid_to_ctrl) begin
        check("rd_addr", bus.mem_addr_to_ctrl, v.base + 32'(4 * reads));
        bus.mem_data_from_ctrl = v.dbase + 32'(reads);
        bus.mem_done_from_ctrl = 1'b1;
        reads++;
      end
    end
    bus.valid_from_if      = 1'b0;
    bus.mem_done_from_ctrl = 1'b0;
    rdy                    = 1'b1;

    check("read_count", 32'(reads), v.hit ? 32'd0 : 32'd4);
    if (v.rb_after >= 0) begin
      check("pulses_after_rollback", 32'(pulses), 32'd0);
    end else begin
      check("pulse_count", 32'(pulses), 32'd1);
      check("inst", got, v.inst);
      check("latency", 32'(lat), 32'(v.lat));
    end
    if (v.hit) exp_hits++;
    else       exp_misses++;
  endtask

  initial begin
    //             pc            hit   base          dbase         inst          rb  st  lat
    vecs[0]  = '{32'h0000_0010, 1'b0, 32'h0000_0010, 32'h0000_00A0, 32'h0000_00A0, -1, -1,  8};
    vecs[1]  = '{32'h0000_0018, 1'b1, 32'h0,         32'h0,         32'h0000_00A2, -1, -1,  1};
    vecs[2]  = '{32'h0000_0110, 1'b0, 32'h0000_0110, 32'h0000_00B0, 32'h0000_00B0, -1, -1,  8};
    vecs[3]  = '{32'h0000_0010, 1'b0, 32'h0000_0010, 32'h0000_00C0, 32'h0000_00C0, -1, -1,  8};
    vecs[4]  = '{32'h0000_001C, 1'b1, 32'h0,         32'h0,         32'h0000_00C3, -1, -1,  1};
    vecs[5]  = '{32'h0000_002C, 1'b0, 32'h0000_0020, 32'h0000_00D0, 32'h0000_00D3, -1, -1,  8};
    vecs[6]  = '{32'h0000_0048, 1'b0, 32'h0000_0040, 32'h0000_00E0, 32'h0,          2, -1,  0};
    vecs[7]  = '{32'h0000_0044, 1'b1, 32'h0,         32'h0,         32'h0000_00E1, -1, -1,  1};
    vecs[8]  = '{32'h0000_0054, 1'b0, 32'h0000_0050, 32'h0000_00F0, 32'h0000_00F1, -1,  1, 11};
    vecs[9]  = '{32'h0000_005C, 1'b1, 32'h0,         32'h0,         32'h0000_00F3, -1, -1,  1};
    vecs[10] = '{32'hFFFF_FFF0, 1'b0, 32'hFFFF_FFF0, 32'h0000_0100, 32'h0000_0100, -1, -1,  8};
    vecs[11] = '{32'hFFFF_FFFC, 1'b1, 32'h0,         32'h0,         32'h0000_0103, -1, -1,  1};

    rst                    = 1'b1;
    rdy                    = 1'b1;
    bus.valid_from_if      = 1'b0;
    bus.pc_from_if         = '0;
    bus.rollback_from_rob  = 1'b0;
    bus.mem_done_from_ctrl = 1'b0;
    bus.mem_data_from_ctrl = '0;

    repeat (2) @(negedge clk);
    cur_vec = -1;
    check("rst_valid_to_if", {31'd0, bus.valid_to_if}, 32'd0);
    check("rst_inst", bus.inst_to_if, 32'd0);
    check("rst_mem_valid", {31'd0, bus.mem_valid_to_ctrl}, 32'd0);
    check("rst_mem_addr", bus.mem_addr_to_ctrl, 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 12; i++) begin
      cur_vec = i;
      run_fetch(vecs[i]);
    end

    // Rollback in IDLE together with a request: the request is ignored that cycle,
    // then served once the flush is gone.
    cur_vec = 50;
    @(negedge clk);
    bus.pc_from_if        = 32'h0000_0018;
    bus.valid_from_if     = 1'b1;
    bus.rollback_from_rob = 1'b1;
    @(negedge clk);
    check("idle_rb_no_pulse", {31'd0, bus.valid_to_if}, 32'd0);
    check("idle_rb_no_mem", {31'd0, bus.mem_valid_to_ctrl}, 32'd0);
    bus.rollback_from_rob = 1'b0;
    @(negedge clk);
    check("idle_rb_pulse", {31'd0, bus.valid_to_if}, 32'd1);
    check("idle_rb_inst", bus.inst_to_if, 32'h0000_00C2);
    exp_hits++;
    @(negedge clk);
    bus.valid_from_if = 1'b0;
    check("idle_rb_single", {31'd0, bus.valid_to_if}, 32'd0);
    @(negedge clk);
    check("idle_rb_quiet", {31'd0, bus.valid_to_if}, 32'd0);

`ifdef ICACHE_PERF_EN
    check("hit_count", hit_count, 32'(exp_hits));
    check("miss_count", miss_count, 32'(exp_misses));
`endif

    // Reset mid-run must invalidate every line.
    cur_vec = 60;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst2_valid_to_if", {31'd0, bus.valid_to_if}, 32'd0);
    check("rst2_mem_addr", bus.mem_addr_to_ctrl, 32'd0);
`ifdef ICACHE_PERF_EN
    check("rst2_hit_count", hit_count, 32'd0);
    check("rst2_miss_count", miss_count, 32'd0);
`endif
    last_vec = '{32'h0000_0018, 1'b0, 32'h0000_0010, 32'h0000_0200, 32'h0000_0202, -1, -1, 8};
    cur_vec = 61;
    run_fetch(last_vec);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
